// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock timekeeping core.
// Holds the mode encoding, BCD limits and the per-digit BCD increment helper.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEC_MAX  = 8'h59;

  localparam int DEBOUNCE_DEFAULT = 500000;

  // Wraps to 00 at the limit; otherwise units 9->0 bumps the tens digit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    if (val == max)        return 8'h00;
    if (val[3:0] == 4'd9)  return {val[7:4] + 4'd1, 4'd0};
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/clock_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted rising edge of the level.
module clock_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic fpga_clk,
  input  logic rstn,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the synchronizer.
  always_ff @(posedge fpga_clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any cycle where the synchronized level agrees restarts the window.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/clock_time_keeper.sv
// BCD hours/minutes/seconds counter with a three-state button-driven
// setting FSM; all outputs come straight from registers.
module clock_time_keeper
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       fpga_clk,
  input  logic       rstn,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] set_mode
);

  logic       w_mode_press;
  logic       w_inc_press;
  mode_e      r_state,  w_state_nxt;
  logic [7:0] r_hour,   w_hour_nxt;
  logic [7:0] r_min,    w_min_nxt;
  logic [7:0] r_sec,    w_sec_nxt;

  clock_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .fpga_clk (fpga_clk),
    .rstn     (rstn),
    .i_btn    (btn_mode),
    .o_press  (w_mode_press)
  );

  clock_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .fpga_clk (fpga_clk),
    .rstn     (rstn),
    .i_btn    (btn_inc),
    .o_press  (w_inc_press)
  );

  always_ff @(posedge fpga_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RUN;
      r_hour  <= 8'h00;
      r_min   <= 8'h00;
      r_sec   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_hour  <= w_hour_nxt;
      r_min   <= w_min_nxt;
      r_sec   <= w_sec_nxt;
    end
  end

  // NOTE: every combinational output is defaulted first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_hour_nxt  = r_hour;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    case (r_state)
      RUN: begin
        if (w_mode_press) w_state_nxt = SET_HOUR;
        if (sec_tick) begin
          w_sec_nxt = bcd_inc(r_sec, SEC_MAX);
          if (r_sec == SEC_MAX) begin
            w_min_nxt = bcd_inc(r_min, MIN_MAX);
            if (r_min == MIN_MAX) w_hour_nxt = bcd_inc(r_hour, HOUR_MAX);
          end
        end
      end
      SET_HOUR: begin
        if (w_mode_press)     w_state_nxt = SET_MIN;
        else if (w_inc_press) w_hour_nxt  = bcd_inc(r_hour, HOUR_MAX);
      end
      SET_MIN: begin
        // Leaving set mode restarts the minute; a coincident tick is dropped.
        if (w_mode_press) begin
          w_state_nxt = RUN;
          w_sec_nxt   = 8'h00;
        end else if (w_inc_press) begin
          w_min_nxt = bcd_inc(r_min, MIN_MAX);
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign hour_bcd = r_hour;
  assign min_bcd  = r_min;
  assign sec_bcd  = r_sec;
  assign set_mode = r_state;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed self-checking bench for clock_time_keeper with a 4-cycle
// debounce window; expected values are hand-computed constants.
module tb_clock_time_keeper;

  localparam int DB = 4;

  logic       fpga_clk;
  logic       rstn;
  logic       sec_tick;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] set_mode;

  int n_total = 0;
  int n_bad   = 0;

  clock_time_keeper #(.DEBOUNCE_CYCLES(DB)) dut (
    .fpga_clk (fpga_clk),
    .rstn     (rstn),
    .sec_tick (sec_tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hour_bcd (hour_bcd),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .set_mode (set_mode)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] now_time();
    return {8'h00, hour_bcd, min_bcd, sec_bcd};
  endfunction

  // which: 0 = mode, 1 = inc, 2 = both in the same cycle
  task automatic press(input int which);
    @(negedge fpga_clk);
    btn_mode = (which != 1);
    btn_inc  = (which != 0);
    repeat (10) @(negedge fpga_clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) @(negedge fpga_clk);
  endtask

  task automatic presses(input int which, input int n);
    for (int i = 0; i < n; i++) press(which);
  endtask

  // Back-to-back ticks on consecutive cycles.
  task automatic ticks(input int n);
    @(negedge fpga_clk);
    sec_tick = 1'b1;
    repeat (n) @(negedge fpga_clk);
    sec_tick = 1'b0;
  endtask

  initial begin
    int waited;
    rstn     = 1'b0;
    sec_tick = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) @(negedge fpga_clk);
    check("reset_time", now_time(), 32'h000000);
    check("reset_mode", set_mode, 2'd0);
    rstn = 1'b1;
    repeat (2) @(negedge fpga_clk);

    // Mode sequence 0 -> 1 -> 2 -> 0
    press(0); check("mode_1", set_mode, 2'd1);
    press(0); check("mode_2", set_mode, 2'd2);
    press(0); check("mode_0", set_mode, 2'd0);
    press(1); check("inc_in_run_ignored", now_time(), 32'h000000);

    // Glitch vs. held inc in SET_HOUR
    press(0);
    @(negedge fpga_clk);
    btn_inc = 1'b1;
    repeat (3) @(negedge fpga_clk);
    btn_inc = 1'b0;
    repeat (15) @(negedge fpga_clk);
    check("glitch_no_press", now_time(), 32'h000000);
    press(1); check("held_one_inc", hour_bcd, 8'h01);
    presses(1, 22); check("hour_23", hour_bcd, 8'h23);
    ticks(3); check("sethour_frozen", now_time(), 32'h230000);
    press(1); check("hour_wrap", now_time(), 32'h000000);
    presses(1, 23);

    // SET_MIN: freeze, minute wrap without carry
    press(0); check("mode_setmin", set_mode, 2'd2);
    ticks(4); check("setmin_frozen", now_time(), 32'h230000);
    presses(1, 59); check("min_59", now_time(), 32'h235900);
    press(1); check("min_wrap", now_time(), 32'h230000);
    presses(1, 58);
    press(0);
    check("run_2358", now_time(), 32'h235800);
    check("run_mode", set_mode, 2'd0);

    // Full ripple 23:59:59 -> 00:00:00 -> 00:00:01
    ticks(119); check("t_235959", now_time(), 32'h235959);
    ticks(1);   check("t_rollover", now_time(), 32'h000000);
    ticks(1);   check("t_000001", now_time(), 32'h000001);

    // Preload 12:34:59 and carry into minutes
    press(0); presses(1, 12);
    press(0); presses(1, 34);
    press(0);
    check("preload_exit", now_time(), 32'h123400);
    ticks(59); check("t_123459", now_time(), 32'h123459);
    ticks(1);  check("t_123500", now_time(), 32'h123500);
    ticks(5);  check("t_123505", now_time(), 32'h123505);

    // Simultaneous mode+inc in SET_HOUR: mode wins
    press(0);
    ticks(3); check("sethour_frozen2", now_time(), 32'h123505);
    press(2);
    check("simul_mode", set_mode, 2'd2);
    check("simul_time", now_time(), 32'h123505);

    // Exit SET_MIN with sec_tick held high: clear wins, tick dropped
    @(negedge fpga_clk);
    btn_mode = 1'b1;
    sec_tick = 1'b1;
    waited = 0;
    while (set_mode != 2'd0 && waited < 20) begin
      @(negedge fpga_clk);
      waited++;
    end
    sec_tick = 1'b0;
    check("exit_tick_mode", set_mode, 2'd0);
    check("exit_tick_time", now_time(), 32'h123500);
    @(negedge fpga_clk);
    check("exit_tick_after", now_time(), 32'h123500);
    btn_mode = 1'b0;
    repeat (10) @(negedge fpga_clk);

    // Reach SET_MIN at 07:42, then reset mid-debounce
    press(0); presses(1, 19);
    press(0); presses(1, 7);
    check("pre_reset_time", now_time(), 32'h074200);
    check("pre_reset_mode", set_mode, 2'd2);
    @(negedge fpga_clk);
    btn_mode = 1'b1;
    repeat (4) @(negedge fpga_clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_time", now_time(), 32'h000000);
    check("async_rst_mode", set_mode, 2'd0);
    repeat (3) @(negedge fpga_clk);
    rstn = 1'b1;
    repeat (DB + 1) @(negedge fpga_clk);
    check("no_early_press", set_mode, 2'd0);
    waited = 0;
    while (set_mode != 2'd1 && waited < 20) begin
      @(negedge fpga_clk);
      waited++;
    end
    check("press_after_window", set_mode, 2'd1);
    btn_mode = 1'b0;
    repeat (10) @(negedge fpga_clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
